hazard_ctrl: RTL

//  Parametrised hazard/forwarding controller for the 5-stage RISC-V pipeline.
//  - Resolves EX operand forwarding from the MEM and WB stages.
//  - Inserts N-cycle load-use bubbles; N is set by the data-memory read latency.
//  - Holds F/D/E while a multi-cycle MDU op completes (start/done handshake).
//  - Flushes and one-shot stalls on taken branches.
//  - Sits between the pipeline registers and the PC/IF-ID/ID-EX enables and clears.

---
 rtl/hazard_pkg.sv | 15 +
 rtl/hazard_fwd_sel.sv | 26 ++
 rtl/hazard_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding and
// forwarding-select codes driven onto the EX operand muxes.
package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LD_HOLD  = 2'd1,
    MDU_WAIT = 2'd2
  } hz_state_t;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forwarding select for one EX operand: MEM result beats WB result, x0 never forwards.
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] rs,
  input  logic [RA_W-1:0] rd_m,
  input  logic [RA_W-1:0] rd_w,
  input  logic            reg_write_m,
  input  logic            reg_write_w,
  output logic [1:0]      sel
);

  always_comb begin
    sel = FWD_NONE;
    if (rs != '0) begin
      if (reg_write_m && (rs == rd_m)) begin
        sel = FWD_MEM;
      end else if (reg_write_w && (rs == rd_w)) begin
        sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage pipeline: forwarding, load-use bubbles,
// MDU hold and branch flush. Optional perf counters under HAZ_PERF_CNT_EN.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int RA_W              = 5,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int BRANCH_STALL      = 1,
  parameter int FLUSH_E_ON_BRANCH = 0
`ifdef HAZ_PERF_CNT_EN
  ,
  parameter int CNT_W             = 32
`endif
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            reg_write_e,
  input  logic            reg_write_m,
  input  logic            reg_write_w,
  input  logic            load_e,
  input  logic            pc_src_e,
  input  logic            mdu_start_e,
  input  logic            mdu_done,
  input  logic [RA_W-1:0] rs1_d,
  input  logic [RA_W-1:0] rs2_d,
  input  logic [RA_W-1:0] rs1_e,
  input  logic [RA_W-1:0] rs2_e,
  input  logic [RA_W-1:0] rd_e,
  input  logic [RA_W-1:0] rd_m,
  input  logic [RA_W-1:0] rd_w,
  output logic            stall_f,
  output logic            stall_d,
  output logic            stall_e,
  output logic            flush_d,
  output logic            flush_e,
  output logic [1:0]      forward_ae,
  output logic [1:0]      forward_be
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  localparam int CNT_WD = $clog2(LOAD_STALL_CYCLES + 1);

  hz_state_t         state, state_nxt;
  logic [CNT_WD-1:0] cnt, cnt_nxt;
  logic              pc_src_q;
  logic              lu_hit;
  logic              br_edge;
  logic [1:0]        sel_a, sel_b;
  logic              unused_reg_write_e;

  // A load always writes its rd, so the EX write enable adds nothing to load-use detection.
  assign unused_reg_write_e = reg_write_e;

  hazard_fwd_sel #(.RA_W(RA_W)) u_fwd_a (
    .rs          (rs1_e),
    .rd_m        (rd_m),
    .rd_w        (rd_w),
    .reg_write_m (reg_write_m),
    .reg_write_w (reg_write_w),
    .sel         (sel_a)
  );

  hazard_fwd_sel #(.RA_W(RA_W)) u_fwd_b (
    .rs          (rs2_e),
    .rd_m        (rd_m),
    .rd_w        (rd_w),
    .reg_write_m (reg_write_m),
    .reg_write_w (reg_write_w),
    .sel         (sel_b)
  );

  assign forward_ae = reset ? FWD_NONE : sel_a;
  assign forward_be = reset ? FWD_NONE : sel_b;

  assign lu_hit  = load_e && (rd_e != '0) && ((rs1_d == rd_e) || (rs2_d == rd_e));
  assign br_edge = pc_src_e && !pc_src_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      pc_src_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      pc_src_q <= pc_src_e;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall_f   = 1'b0;
    stall_d   = 1'b0;
    stall_e   = 1'b0;
    flush_d   = 1'b0;
    flush_e   = 1'b0;
    unique case (state)
      IDLE: begin
        // A taken branch makes the D-stage instruction wrong-path, so its load-use hit is moot.
        if (pc_src_e) begin
          flush_d = 1'b1;
          flush_e = (FLUSH_E_ON_BRANCH != 0);
          stall_f = (BRANCH_STALL != 0) && br_edge;
          stall_d = (BRANCH_STALL != 0) && br_edge;
        end else if (mdu_start_e && !mdu_done) begin
          stall_f   = 1'b1;
          stall_d   = 1'b1;
          stall_e   = 1'b1;
          state_nxt = MDU_WAIT;
        end else if (mdu_start_e && mdu_done) begin
          state_nxt = IDLE;
        end else if (lu_hit) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          flush_e = 1'b1;
          if (LOAD_STALL_CYCLES > 1) begin
            cnt_nxt   = CNT_WD'(LOAD_STALL_CYCLES - 1);
            state_nxt = LD_HOLD;
          end
        end
      end
      LD_HOLD: begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
        cnt_nxt = cnt - CNT_WD'(1);
        if (cnt == CNT_WD'(1)) begin
          state_nxt = IDLE;
        end
      end
      MDU_WAIT: begin
        if (!mdu_done) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          stall_e = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (reset) begin
      stall_f = 1'b0;
      stall_d = 1'b0;
      stall_e = 1'b0;
      flush_d = 1'b0;
      flush_e = 1'b0;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_f && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if ((flush_d || flush_e) && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule
